// File: rtl/bubble_pkg.sv
// Shared constants and helpers for the bubble emulator front-panel path.
package bubble_pkg;

    localparam int MCLK_HZ             = 48_000_000;
    localparam int HOLD_CYCLES_DEFAULT = MCLK_HZ / 20;

    localparam logic [2:0] ACC_ACTIVE = 3'b100;
    localparam logic [2:0] ACC_IDLE   = 3'b000;
    localparam logic [2:0] ACC_READ   = 3'b101;
    localparam logic [2:0] ACC_WRITE  = 3'b110;

    typedef enum logic [1:0] {
        BCD_IDLE,
        BCD_SHIFT,
        BCD_DONE
    } bcd_state_t;

    // Double-dabble correction: every digit >= 5 gets +3 before the shift.
    function automatic logic [15:0] bcd_adjust(input logic [15:0] digits);
        logic [15:0] res;
        res = digits;
        for (int i = 0; i < 4; i++) begin
            if (digits[i*4 +: 4] >= 4'd5)
                res[i*4 +: 4] = digits[i*4 +: 4] + 4'd3;
        end
        return res;
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// 12-bit serial double-dabble: one shift per cycle, 4-digit BCD result in DONE.
module bin2bcd_serial
    import bubble_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] din,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd
);

    bcd_state_t  state_q, state_d;
    logic [27:0] sreg;
    logic [3:0]  cnt;
    logic [27:0] adj;

    assign adj  = {bcd_adjust(sreg[27:12]), sreg[11:0]};
    assign busy = (state_q != BCD_IDLE);
    assign done = (state_q == BCD_DONE);
    assign bcd  = sreg[27:12];

    always_comb begin
        state_d = state_q;
        case (state_q)
            BCD_IDLE:  if (start) state_d = BCD_SHIFT;
            BCD_SHIFT: if (cnt == 4'd11) state_d = BCD_DONE;
            BCD_DONE:  state_d = start ? BCD_SHIFT : BCD_IDLE;
            default:   state_d = BCD_IDLE;
        endcase
    end

    // A start in DONE reloads immediately so chained conversions skip IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BCD_IDLE;
            sreg    <= '0;
            cnt     <= '0;
        end else begin
            state_q <= state_d;
            if (start && state_q != BCD_SHIFT) begin
                sreg <= {16'b0, din};
                cnt  <= '0;
            end else if (state_q == BCD_SHIFT) begin
                sreg <= {adj[26:0], 1'b0};
                cnt  <= cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/access_status_conditioner.sv
// Conditions emulator status for the LED/7-segment driver: wait register,
// access-type stretch and binary-to-decimal page conversion.
module access_status_conditioner
    import bubble_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
    parameter bit DECIMAL     = 1'b1
) (
    input  logic        MCLK,
    input  logic        RESET,
    input  logic        nWAIT_IN,
    input  logic [2:0]  ACCTYPE_IN,
    input  logic [11:0] PAGE_IN,
    input  logic        PAGE_STB,
    output logic        nWAIT,
    output logic [2:0]  ACCTYPE,
    output logic [11:0] CURRPAGE,
    output logic        BUSY,
    output logic        OVERFLOW
);

    localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TW-1:0] RELOAD = TW'(HOLD_CYCLES - 1);

    logic [TW-1:0] timer;
    logic          acc_active;

    assign acc_active = |(ACCTYPE_IN & ACC_ACTIVE);

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            nWAIT   <= 1'b1;
            ACCTYPE <= ACC_IDLE;
            timer   <= '0;
        end else begin
            nWAIT <= nWAIT_IN;
            if (acc_active) begin
                ACCTYPE <= ACCTYPE_IN;
                timer   <= RELOAD;
            end else if (timer != '0) begin
                timer <= timer - 1'b1;
            end else begin
                ACCTYPE <= ACCTYPE_IN;
            end
        end
    end

    if (DECIMAL) begin : g_bcd
        logic        conv_start, conv_busy, conv_done;
        logic [11:0] conv_din;
        logic [15:0] conv_bcd;
        logic        pend_vld;
        logic [11:0] pend;

        // A strobe coinciding with DONE is the newest pending value.
        assign conv_start = (!conv_busy && PAGE_STB) ||
                            (conv_done && (pend_vld || PAGE_STB));
        assign conv_din   = (conv_done && !PAGE_STB) ? pend : PAGE_IN;
        assign BUSY       = conv_busy;

        bin2bcd_serial u_conv (
            .clk   (MCLK),
            .rst   (RESET),
            .start (conv_start),
            .din   (conv_din),
            .busy  (conv_busy),
            .done  (conv_done),
            .bcd   (conv_bcd)
        );

        always_ff @(posedge MCLK) begin
            if (RESET) begin
                CURRPAGE <= '0;
                OVERFLOW <= 1'b0;
                pend_vld <= 1'b0;
                pend     <= '0;
            end else if (conv_done) begin
                pend_vld <= 1'b0;
                if (conv_bcd[15:12] != 4'd0) begin
                    CURRPAGE <= 12'h999;
                    OVERFLOW <= 1'b1;
                end else begin
                    CURRPAGE <= conv_bcd[11:0];
                    OVERFLOW <= 1'b0;
                end
            end else if (PAGE_STB && conv_busy) begin
                pend     <= PAGE_IN;
                pend_vld <= 1'b1;
            end
        end
    end else begin : g_bin
        assign BUSY     = 1'b0;
        assign OVERFLOW = 1'b0;

        always_ff @(posedge MCLK) begin
            if (RESET)
                CURRPAGE <= '0;
            else if (PAGE_STB)
                CURRPAGE <= PAGE_IN;
        end
    end

endmodule
